// File: rtl/scan_pkg.sv
// Shared constants and types for the scan-interface receive path.
package scan_pkg;

  localparam int DIGIT_W = 4;
  localparam int DIGIT_N = 4;

  localparam logic [DIGIT_N-1:0] SEL_BLANK = 4'b0000;
  localparam logic [DIGIT_N-1:0] SEL_D3    = 4'b1000;
  localparam logic [DIGIT_N-1:0] SEL_D2    = 4'b0100;
  localparam logic [DIGIT_N-1:0] SEL_D1    = 4'b0010;
  localparam logic [DIGIT_N-1:0] SEL_D0    = 4'b0001;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    EXP_D2    = 2'd1,
    EXP_D1    = 2'd2,
    EXP_D0    = 2'd3
  } scan_state_t;

  function automatic logic is_one_hot(input logic [DIGIT_N-1:0] s);
    return (s != '0) && ((s & (s - DIGIT_N'(1))) == '0);
  endfunction

endpackage

// File: rtl/scan_capture_if.sv
// Scanner-facing inputs and frame/status outputs of the capture block.
interface scan_capture_if;
  import scan_pkg::*;

  logic [DIGIT_N-1:0]         select;
  logic [DIGIT_W-1:0]         segment;
  logic [DIGIT_W*DIGIT_N-1:0] digits;
  logic                       frame_valid;
  logic                       sel_err;
  logic                       order_err;
  logic                       timeout_err;
  logic                       link_up;

  // Scanner / harness side.
  modport master (
    output select, segment,
    input  digits, frame_valid, sel_err, order_err, timeout_err, link_up
  );

  // Capture side.
  modport slave (
    input  select, segment,
    output digits, frame_valid, sel_err, order_err, timeout_err, link_up
  );
endinterface

// File: rtl/scan_debounce.sv
// Stability filter: a value is accepted once it has been seen unchanged on
// STABLE_CYCLES consecutive edges after it first appeared. The accept strobe
// is combinational from the registered history so the consumer acts on the
// same edge that completes the window.
module scan_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             accept
);

  localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] CNT_FULL = 4'(STABLE_CYCLES);

  logic [WIDTH-1:0] prev;
  logic [3:0]       hold_cnt;

  assign dout   = prev;
  assign accept = (din == prev) && (hold_cnt == CNT_LAST);

  // Track previous sample and count matching edges; saturate so the
  // window fires only once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev     <= '0;
      hold_cnt <= '0;
    end else begin
      prev <= din;
      if (din != prev)
        hold_cnt <= '0;
      else if (hold_cnt != CNT_FULL)
        hold_cnt <= hold_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/scan_capture.sv
// Receive side of the 4-digit multiplexed scan interface: filters each
// select/code pair, enforces digit order 3->2->1->0 and publishes frames.
//
// state     | meaning
// WAIT_SYNC | idle, waiting for digit3 select to start a frame
// EXP_D2    | digit3 staged, expecting digit2
// EXP_D1    | digit2 staged, expecting digit1
// EXP_D0    | digit1 staged, expecting digit0 to complete the frame
module scan_capture
  import scan_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  scan_capture_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [DIGIT_N+DIGIT_W-1:0] stable;
  logic                       acc;
  logic [DIGIT_N-1:0]         sel;
  logic [DIGIT_W-1:0]         seg;

  scan_state_t        state;
  logic [DIGIT_N-1:0] last_sel;
  logic [DIGIT_W-1:0] stage3, stage2, stage1;
  logic [TW-1:0]      tmo_cnt;

  scan_debounce #(
    .WIDTH         (DIGIT_N + DIGIT_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    ({bus.select, bus.segment}),
    .dout   (stable),
    .accept (acc)
  );

  assign sel = stable[DIGIT_N+DIGIT_W-1:DIGIT_W];
  assign seg = stable[DIGIT_W-1:0];

  // Frame sequencer: classify each accepted pair, stage digits, raise
  // one-cycle status pulses and supervise the inter-accept timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= WAIT_SYNC;
      last_sel        <= SEL_BLANK;
      stage3          <= '0;
      stage2          <= '0;
      stage1          <= '0;
      tmo_cnt         <= '0;
      bus.digits      <= '0;
      bus.frame_valid <= 1'b0;
      bus.sel_err     <= 1'b0;
      bus.order_err   <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.link_up     <= 1'b0;
    end else begin
      bus.frame_valid <= 1'b0;
      bus.sel_err     <= 1'b0;
      bus.order_err   <= 1'b0;
      bus.timeout_err <= 1'b0;

      if (state != WAIT_SYNC)
        tmo_cnt <= tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;

      if (acc) begin
        tmo_cnt  <= '0;
        last_sel <= sel;
        if (sel == SEL_BLANK) begin
          state  <= WAIT_SYNC;
          stage3 <= '0;
          stage2 <= '0;
          stage1 <= '0;
        end else if (!is_one_hot(sel)) begin
          bus.sel_err <= 1'b1;
          bus.link_up <= 1'b0;
          state       <= WAIT_SYNC;
          stage3      <= '0;
          stage2      <= '0;
          stage1      <= '0;
        end else if (sel == last_sel) begin
          // Only the code changed: refresh that digit, sequence untouched.
          case (sel)
            SEL_D3:  stage3 <= seg;
            SEL_D2:  stage2 <= seg;
            SEL_D1:  stage1 <= seg;
            default: ;
          endcase
        end else begin
          case (state)
            WAIT_SYNC: begin
              if (sel == SEL_D3) begin
                stage3 <= seg;
                state  <= EXP_D2;
              end
            end
            EXP_D2: begin
              if (sel == SEL_D2) begin
                stage2 <= seg;
                state  <= EXP_D1;
              end else begin
                bus.order_err <= 1'b1;
                if (sel == SEL_D3) stage3 <= seg;
                state <= (sel == SEL_D3) ? EXP_D2 : WAIT_SYNC;
              end
            end
            EXP_D1: begin
              if (sel == SEL_D1) begin
                stage1 <= seg;
                state  <= EXP_D0;
              end else begin
                bus.order_err <= 1'b1;
                if (sel == SEL_D3) stage3 <= seg;
                state <= (sel == SEL_D3) ? EXP_D2 : WAIT_SYNC;
              end
            end
            EXP_D0: begin
              if (sel == SEL_D0) begin
                bus.digits      <= {stage3, stage2, stage1, seg};
                bus.frame_valid <= 1'b1;
                bus.link_up     <= 1'b1;
                state           <= WAIT_SYNC;
              end else begin
                bus.order_err <= 1'b1;
                if (sel == SEL_D3) stage3 <= seg;
                state <= (sel == SEL_D3) ? EXP_D2 : WAIT_SYNC;
              end
            end
          endcase
        end
      end else if (state != WAIT_SYNC && tmo_cnt == TMO_LAST) begin
        bus.timeout_err <= 1'b1;
        bus.link_up     <= 1'b0;
        state           <= WAIT_SYNC;
        tmo_cnt         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_scan_capture.sv
// Directed bench for scan_capture with an event scoreboard on the pulses.
module tb_scan_capture;
  import scan_pkg::*;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 256;
  localparam int DPER    = 66;

  localparam logic [3:0] EV_FRAME = 4'b1000;
  localparam logic [3:0] EV_SEL   = 4'b0100;
  localparam logic [3:0] EV_ORDER = 4'b0010;
  localparam logic [3:0] EV_TMO   = 4'b0001;

  typedef struct {
    logic [3:0]  kind;
    logic [15:0] digits;
    logic        link;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  sb[$];

  scan_capture_if bus ();

  scan_capture #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] kind, input logic [15:0] d, input logic link);
    ev_t e;
    e.kind   = kind;
    e.digits = d;
    e.link   = link;
    sb.push_back(e);
  endtask

  // Called at a negedge; holds the pair for exactly `cycles` rising edges.
  task automatic apply(input logic [3:0] s, input logic [3:0] g, input int cycles);
    bus.select  = s;
    bus.segment = g;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic frame(input logic [15:0] d, input logic link_after);
    apply(SEL_D3, d[15:12], DPER);
    apply(SEL_D2, d[11:8], DPER);
    apply(SEL_D1, d[7:4], DPER);
    push(EV_FRAME, d, link_after);
    apply(SEL_D0, d[3:0], DPER);
  endtask

  // Every pulse must match the next expected event.
  always @(negedge clk) begin
    logic [3:0] k;
    ev_t e;
    k = {bus.frame_valid, bus.sel_err, bus.order_err, bus.timeout_err};
    if (k != 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {28'd0, k}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {28'd0, k}, {28'd0, e.kind});
        check("pulse_digits", {16'd0, bus.digits}, {16'd0, e.digits});
        check("pulse_link", {31'd0, bus.link_up}, {31'd0, e.link});
      end
    end
  end

  initial begin
    int lat;
    rst_n       = 1'b0;
    bus.select  = 4'b0000;
    bus.segment = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_digits", {16'd0, bus.digits}, 32'd0);
    check("rst_link", {31'd0, bus.link_up}, 32'd0);
    check("rst_pulses", {28'd0, bus.frame_valid, bus.sel_err, bus.order_err, bus.timeout_err}, 32'd0);
    rst_n = 1'b1;

    // Clean frame with latency measurement on the last digit.
    apply(SEL_D3, 4'h1, DPER);
    apply(SEL_D2, 4'h2, DPER);
    apply(SEL_D1, 4'h3, DPER);
    push(EV_FRAME, 16'h1234, 1'b1);
    bus.select  = SEL_D0;
    bus.segment = 4'h4;
    lat = -1;
    for (int k = 1; k <= DPER; k++) begin
      @(negedge clk);
      if (lat < 0 && bus.frame_valid) lat = k - 1;
    end
    check("frame_latency", lat, STABLE);
    check("clean_digits", {16'd0, bus.digits}, 32'h1234);
    check("clean_link", {31'd0, bus.link_up}, 32'd1);

    // Short glitch on digit2 code must not be staged.
    apply(SEL_D3, 4'h1, DPER);
    apply(SEL_D2, 4'h2, 30);
    apply(SEL_D2, 4'h7, 2);
    apply(SEL_D2, 4'h2, 34);
    apply(SEL_D1, 4'h3, DPER);
    push(EV_FRAME, 16'h1234, 1'b1);
    apply(SEL_D0, 4'h4, DPER);
    check("glitch_digits", {16'd0, bus.digits}, 32'h1234);

    // Out-of-order digit, then recovery.
    apply(SEL_D3, 4'h9, DPER);
    push(EV_ORDER, 16'h1234, 1'b1);
    apply(SEL_D1, 4'h5, DPER);
    check("order_digits", {16'd0, bus.digits}, 32'h1234);
    frame(16'h5678, 1'b1);
    check("recover_digits", {16'd0, bus.digits}, 32'h5678);

    // Non-one-hot select mid-frame.
    apply(SEL_D3, 4'h1, DPER);
    apply(SEL_D2, 4'h2, DPER);
    push(EV_SEL, 16'h5678, 1'b0);
    apply(4'b0110, 4'h3, DPER);
    check("selerr_link", {31'd0, bus.link_up}, 32'd0);
    frame(16'h9abc, 1'b1);
    check("after_sel_digits", {16'd0, bus.digits}, 32'h9abc);
    check("after_sel_link", {31'd0, bus.link_up}, 32'd1);

    // Blank mid-frame: silent return to sync; stray digits ignored.
    apply(SEL_D3, 4'h1, DPER);
    apply(SEL_D2, 4'h2, DPER);
    apply(SEL_BLANK, 4'h0, DPER);
    apply(SEL_D1, 4'h3, DPER);
    apply(SEL_D0, 4'h4, DPER);
    check("blank_digits", {16'd0, bus.digits}, 32'h9abc);
    check("blank_link", {31'd0, bus.link_up}, 32'd1);

    // Timeout after a lone digit3.
    apply(SEL_BLANK, 4'h0, 10);
    push(EV_TMO, 16'h9abc, 1'b0);
    bus.select  = SEL_D3;
    bus.segment = 4'h1;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (lat < 0 && bus.timeout_err) lat = k - 1 - STABLE;
    end
    check("timeout_latency", lat, TIMEOUT);
    check("timeout_link", {31'd0, bus.link_up}, 32'd0);
    check("timeout_digits", {16'd0, bus.digits}, 32'h9abc);

    // Reset while in EXP_D1 clears everything without a pulse.
    apply(SEL_BLANK, 4'h0, 10);
    apply(SEL_D3, 4'h2, DPER);
    apply(SEL_D2, 4'h4, 20);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_digits", {16'd0, bus.digits}, 32'd0);
    check("midrst_link", {31'd0, bus.link_up}, 32'd0);
    check("midrst_pulses", {28'd0, bus.frame_valid, bus.sel_err, bus.order_err, bus.timeout_err}, 32'd0);
    rst_n = 1'b1;
    apply(SEL_D2, 4'h4, 45);
    apply(SEL_D1, 4'h6, DPER);
    apply(SEL_D0, 4'h8, DPER);
    check("postrst_digits", {16'd0, bus.digits}, 32'd0);
    apply(SEL_BLANK, 4'h0, 10);
    frame(16'h1357, 1'b1);
    check("final_digits", {16'd0, bus.digits}, 32'h1357);
    check("final_link", {31'd0, bus.link_up}, 32'd1);

    apply(SEL_BLANK, 4'h0, 10);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
